// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: DEPTH-entry in-order instruction prefetch buffer between imem_ctrl and decode.
// Define KRV_PFQ_BYPASS_EN to let a live response reach decode in the same cycle when the queue is empty.
module if_prefetch_queue #(
    parameter int ADDR_WIDTH      = 32,
    parameter int INSTR_WIDTH     = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    input  logic [ADDR_WIDTH-1:0]  boot_addr,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   rsp_valid,
    input  logic [INSTR_WIDTH-1:0] rsp_data,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] instr_dec,
    output logic [ADDR_WIDTH-1:0]  pc_dec,
    output logic [ADDR_WIDTH-1:0]  pc_plus4_dec,
    input  logic                   dec_ready,
    output logic                   pc_misaligned,
    output logic [ADDR_WIDTH-1:0]  fault_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]  rsp_pc_q, rsp_pc_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       pending_q, pending_d;
    logic [CNT_W-1:0]       drop_q, drop_d;
    logic                   halt_q, halt_d;
    logic [ADDR_WIDTH-1:0]  fault_pc_q, fault_pc_d;

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];

    logic                   req_fire;
    logic                   rsp_live;
    logic                   bypass;
    logic                   push;
    logic                   pop_mem;
    logic                   misaligned;
    logic [CNT_W-1:0]       live_pending;
    logic [CNT_W:0]         occupancy;
    logic                   head_valid;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic [ADDR_WIDTH-1:0]  head_pc;

    // Live requests reserve a queue slot so every accepted response is guaranteed room.
    assign live_pending = pending_q - drop_q;
    assign occupancy    = {1'b0, count_q} + {1'b0, live_pending};
    assign req_valid    = !halt_q && !redirect && (pending_q < MAX_OUT_C) && (occupancy < DEPTH_C);
    assign req_addr     = fetch_pc_q;
    assign req_fire     = req_valid && req_ready;

    assign misaligned   = |redirect_pc[1:0];
    assign rsp_live     = rsp_valid && !redirect && (drop_q == '0);

`ifdef KRV_PFQ_BYPASS_EN
    assign bypass       = rsp_live && (count_q == '0);
    assign head_instr   = bypass ? rsp_data : instr_mem[rd_ptr_q];
    assign head_pc      = bypass ? rsp_pc_q : pc_mem[rd_ptr_q];
`else
    assign bypass       = 1'b0;
    assign head_instr   = instr_mem[rd_ptr_q];
    assign head_pc      = pc_mem[rd_ptr_q];
`endif

    assign head_valid   = (count_q != '0) || bypass;
    assign push         = rsp_live && !(bypass && dec_ready);
    assign pop_mem      = (count_q != '0) && dec_ready && !redirect;

    // Gating keeps the unreset storage from ever showing up on the outputs.
    assign if_valid      = head_valid;
    assign instr_dec     = head_valid ? head_instr : '0;
    assign pc_dec        = head_valid ? head_pc : '0;
    assign pc_plus4_dec  = head_valid ? head_pc + ADDR_WIDTH'(4) : '0;
    assign pc_misaligned = halt_q;
    assign fault_pc      = fault_pc_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latches).
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pending_d  = pending_q;
        drop_d     = drop_q;
        halt_d     = halt_q;
        fault_pc_d = fault_pc_q;

        if (redirect) begin
            // Everything still in flight belongs to the old stream, including a response arriving now.
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
            pending_d  = pending_q - CNT_W'(rsp_valid);
            drop_d     = pending_q - CNT_W'(rsp_valid);
            halt_d     = misaligned;
            fault_pc_d = misaligned ? redirect_pc : '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
            pending_d = pending_q + CNT_W'(req_fire) - CNT_W'(rsp_valid);
            if (rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            // Fetch is sequential, so the next live response's PC is just a running stream PC.
            if (rsp_live) begin
                rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(4);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_mem) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop_mem);
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            fetch_pc_q <= boot_addr;
            rsp_pc_q   <= boot_addr;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            drop_q     <= '0;
            halt_q     <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            halt_q     <= halt_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge cpu_clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= rsp_data;
            pc_mem[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Parametrised instruction prefetch queue. It replaces the single-register IF→DEC hand-off with a DEPTH-entry in-order buffer. It sits between imem_ctrl and the decode stage. It issues sequential fetch requests ahead of decode with up to MAX_OUTSTANDING requests in flight, and discards stale responses after a redirect from the trap, branch or jump logic.

## Interface
- ADDR_WIDTH, 32, fetch address width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of 2, ≥2
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests; 1..DEPTH

Clock and reset: one clock; reset is asynchronous and active-low.

Ports:
- cpu_clk  in  1  cpu clock
- cpu_rstn  in  1  asynchronous reset, active low
- boot_addr  in  ADDR_WIDTH  first fetch address after reset
- redirect  in  1  flush queue and restart fetch
- redirect_pc  in  ADDR_WIDTH  new fetch address
- req_valid  out  1  fetch request to imem
- req_ready  in  1  imem accepts request
- req_addr  out  ADDR_WIDTH  fetch address
- rsp_valid  in  1  imem response; strictly in request order, ≥1 cycle after acceptance
- rsp_data  in  INSTR_WIDTH  fetched instruction
- if_valid  out  1  queue head valid to DEC
- instr_dec  out  INSTR_WIDTH  head instruction
- pc_dec  out  ADDR_WIDTH  head PC
- pc_plus4_dec  out  ADDR_WIDTH  head PC + 4
- dec_ready  in  1  DEC consumes head when if_valid is high
- pc_misaligned  out  1  redirect_pc[1:0] != 0 latched
- fault_pc  out  ADDR_WIDTH  latched misaligned PC, else 0

## Operation
- State:
  - fetch_pc
  - queue storage {instr, pc} × DEPTH, with rd_ptr and wr_ptr of width log2(DEPTH)
  - count, width log2(DEPTH)+1
  - pending (in-flight requests)
  - drop_cnt (responses still to discard)
  - halt flag
- Issue condition: req_valid = !halt && !redirect && pending < MAX_OUTSTANDING && count + (pending − drop_cnt) < DEPTH.
- req_addr = fetch_pc.
- On req_valid && req_ready:
  - fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH
  - pending += 1
- PC tag: each live request's PC is carried in a pending-PC FIFO of depth MAX_OUTSTANDING, or equivalently derived as the head PC of the live stream.
- Response handling, on rsp_valid:
  - pending −= 1
  - if drop_cnt > 0: drop_cnt −= 1 and the data is discarded
  - otherwise: write {rsp_data, tagged pc} at wr_ptr, then count += 1
- Pop: if_valid && dec_ready && !redirect → rd_ptr += 1, count −= 1.
- Simultaneous push and pop: count is unchanged.
- Outputs: if_valid = (count != 0); instr_dec, pc_dec and pc_plus4_dec come from the rd_ptr entry.
- Redirect, in the cycle it is asserted:
  - count ← 0, and rd_ptr ← wr_ptr
  - drop_cnt ← pending − (rsp_valid ? 1 : 0); any rsp_valid in that cycle is discarded
  - fetch_pc ← redirect_pc
  - halt ← (redirect_pc[1:0] != 0)
  - no request is issued and no pop occurs
- Misaligned redirect: pc_misaligned = 1 and fault_pc = redirect_pc, both held until the next aligned redirect. While halted, req_valid stays 0.
- Redirect while drop_cnt > 0: the new drop_cnt still equals all remaining pending requests.

## Timing
- Reset values:
  - fetch_pc = boot_addr
  - count = pending = drop_cnt = 0, pointers = 0, halt = 0
  - if_valid = 0, instr_dec = 0, pc_dec = pc_plus4_dec = 0
  - req_valid asserts in the first cycle after reset release
  - pc_misaligned = 0, fault_pc = 0
- Request issue: combinational from state, one request per cycle maximum.
- Latency without bypass: a response in cycle N is visible on if_valid in cycle N+1.
- Steady state: with single-cycle imem and MAX_OUTSTANDING ≥ 2, one instruction per cycle to DEC.
- Redirect at cycle N: if_valid = 0 at N+1; req_valid with redirect_pc at N+1 (aligned case).
- Reset asserted mid-operation: all state clears immediately; in-flight imem responses after reset are the imem_ctrl's responsibility to squash.

## Configuration
- KRV_PFQ_BYPASS_EN defined:
  - When count == 0 and a live (non-dropped) rsp_valid arrives, if_valid = 1 in the same cycle, with head data = rsp_data and pc.
  - If dec_ready is also high, the entry is not written.
  - Zero-cycle latency when empty.
- Undefined: no combinational path from rsp_* to if_valid/instr_dec; latency is 1 cycle as above.

## Test plan
- Reset with boot_addr=0x100, req_ready=1, 1-cycle imem, dec_ready=1 → req_addr sequence 0x100, 0x104, 0x108…; pc_dec follows the same sequence, one instruction per cycle with no gaps.
- dec_ready=0 with DEPTH=4 → exactly 4 responses accepted, then req_valid=0; releasing dec_ready → instructions delivered in order 0x100..0x10C.
- Redirect to 0x200 while 2 requests are pending → both stale responses discarded; the next pc_dec is 0x200, with if_valid=0 in the cycle after the redirect.
- Redirect coincident with rsp_valid and with another redirect during the drop window → no stale instruction ever appears; drop_cnt returns to 0.
- redirect_pc=0x202 → pc_misaligned=1, fault_pc=0x202, req_valid=0; a subsequent redirect to 0x300 clears both and fetch resumes at 0x300.
- With KRV_PFQ_BYPASS_EN: empty queue, response for 0x100 → if_valid=1 in the same cycle; without the macro → if_valid=1 one cycle later.
